// File: rtl/inst_ram_loader.sv
// inst_ram_loader: 64x32 instruction memory filled from a big-endian byte stream, read combinationally by fetch.
module inst_ram_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [6:0]        word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] a,
  output logic [31:0]       inst
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_nx;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_r;
  logic [6:0]        n_words;
  logic              accept, last_byte;
  assign accept    = byte_valid && byte_ready;
  assign last_byte = accept && byte_cnt == 2'd3 && 7'(wr_ptr) == n_words - 7'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (load_start ? (word_count == 7'd0 ? DONE : LOAD) : IDLE) :
               state == LOAD ? (last_byte ? DONE : LOAD) : IDLE;
  end
  always_comb begin
    busy       = state == LOAD;
    byte_ready = state == LOAD;
    done       = state == DONE;
  end
  // Counts above DEPTH are clamped so a load never wraps onto earlier words.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      byte_cnt <= '0;
      asm_r    <= '0;
      n_words  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == IDLE && load_start) begin
      wr_ptr   <= '0;
      byte_cnt <= '0;
      n_words  <= word_count > 7'(DEPTH) ? 7'(DEPTH) : word_count;
    end else if (accept) begin
      if (byte_cnt == 2'd3) begin
        mem[wr_ptr] <= {asm_r, byte_in};
        byte_cnt    <= '0;
        wr_ptr      <= wr_ptr + ADDR_W'(1);
      end else begin
        asm_r    <= {asm_r[15:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  assign inst = busy ? 32'h0000_0000 : mem[a];
endmodule
